// File: rtl/monty_final_sub_if.sv
// rtl/monty_final_sub_if.sv - input/output stream handshake bundle for monty_final_sub
interface monty_final_sub_if #(
    parameter int Q_LEN = 60,
    parameter int T_LEN = Q_LEN + 1
);
    logic             in_valid;
    logic             in_ready;
    logic [T_LEN-1:0] T;
    logic             out_valid;
    logic             out_ready;
    logic [Q_LEN-1:0] Z;

    modport master (
        output in_valid, T, out_ready,
        input  in_ready, out_valid, Z
    );

    modport slave (
        input  in_valid, T, out_ready,
        output in_ready, out_valid, Z
    );
endinterface

// File: rtl/monty_final_sub.sv
// rtl/monty_final_sub.sv - Montgomery final conditional subtract (T in [0,2q) -> Z in [0,q)) with credit-managed output FIFO
// Optional input register stage S0 enabled by defining MONTY_FINAL_SUB_FF_IN_EN.
module monty_final_sub #(
    parameter int Q_LEN = 60,
    parameter int T_LEN = Q_LEN + 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Q_LEN-1:0] q,
    monty_final_sub_if.slave s
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0]    credits;
    logic [CW-1:0]    buf_cnt;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [Q_LEN-1:0] mem [DEPTH];

    logic             in_fire;
    logic             out_fire;
    logic             s1_in_valid;
    logic [T_LEN-1:0] s1_in_t;

    logic             s1_valid;
    logic             s1_borrow;
    logic [Q_LEN-1:0] s1_d;
    logic [Q_LEN-1:0] s1_t;

    assign in_fire     = s.in_valid && s.in_ready;
    assign out_fire    = s.out_valid && s.out_ready;
    assign s.in_ready  = rst && (credits < DEPTH_C);
    assign s.out_valid = (buf_cnt != '0);
    assign s.Z         = rst ? mem[rd_ptr] : '0;

`ifdef MONTY_FINAL_SUB_FF_IN_EN
    logic             s0_valid;
    logic [T_LEN-1:0] s0_t;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_valid <= 1'b0;
            s0_t     <= '0;
        end else begin
            s0_valid <= in_fire;
            if (in_fire) begin
                s0_t <= s.T;
            end
        end
    end

    assign s1_in_valid = s0_valid;
    assign s1_in_t     = s0_t;
`else
    assign s1_in_valid = in_fire;
    assign s1_in_t     = s.T;
`endif

    // The T_LEN+1-bit difference is kept as its borrow bit plus the low Q_LEN
    // bits, which are the only parts of D the select stage ever looks at.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_borrow <= 1'b0;
            s1_d      <= '0;
            s1_t      <= '0;
        end else begin
            s1_valid <= s1_in_valid;
            if (s1_in_valid) begin
                s1_borrow <= (s1_in_t < T_LEN'(q));
                s1_d      <= s1_in_t[Q_LEN-1:0] - q;
                s1_t      <= s1_in_t[Q_LEN-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s1_valid) begin
            mem[wr_ptr] <= s1_borrow ? s1_t : s1_d;
        end
    end

    // Credits cover every item from acceptance until it leaves, so S1 never
    // needs to stall: a slot is always free when it writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            buf_cnt <= '0;
            credits <= '0;
        end else begin
            if (s1_valid) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (out_fire) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({s1_valid, out_fire})
                2'b10:   buf_cnt <= buf_cnt + CW'(1);
                2'b01:   buf_cnt <= buf_cnt - CW'(1);
                default: buf_cnt <= buf_cnt;
            endcase
            case ({in_fire, out_fire})
                2'b10:   credits <= credits + CW'(1);
                2'b01:   credits <= credits - CW'(1);
                default: credits <= credits;
            endcase
        end
    end
endmodule

// File: tb/tb_monty_final_sub.sv
// tb/tb_monty_final_sub.sv - directed self-checking bench for monty_final_sub
module tb_monty_final_sub;
    localparam int Q_LEN = 8;
    localparam int T_LEN = 9;
    localparam int DEPTH = 4;
    localparam int QMOD  = 251;
`ifdef MONTY_FINAL_SUB_FF_IN_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        int t;
        int z;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [Q_LEN-1:0] q   = 8'd251;

    monty_final_sub_if #(.Q_LEN(Q_LEN), .T_LEN(T_LEN)) bus ();

    monty_final_sub #(.Q_LEN(Q_LEN), .T_LEN(T_LEN), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .q  (q),
        .s  (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int send_q[$];
    int exp_q[$];
    int got_q[$];
    int inflight, max_inflight, cyc, first_pop, last_pop, stalls, ready_mode;
    vec_t vecs[8];

    function automatic int model(int t);
        if (t >= QMOD) return (t - QMOD) % 256;
        return t;
    endfunction

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear();
        send_q.delete();
        exp_q.delete();
        got_q.delete();
        inflight     = 0;
        max_inflight = 0;
        first_pop    = -1;
        last_pop     = -1;
        stalls       = 0;
    endtask

    initial begin
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                if (bus.in_valid && bus.in_ready) begin
                    exp_q.push_back(model(int'(bus.T)));
                    if (send_q.size() > 0) void'(send_q.pop_front());
                    inflight++;
                end
                if (bus.out_valid && bus.out_ready) begin
                    got_q.push_back(int'(bus.Z));
                    inflight--;
                    if (first_pop < 0) first_pop = cyc;
                    last_pop = cyc;
                end
                if (inflight > max_inflight) max_inflight = inflight;
            end
        end
    end

    task automatic step(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = ~bus.out_ready;
            endcase
            if (send_q.size() > 0) begin
                bus.in_valid = 1'b1;
                bus.T        = 9'(send_q[0]);
                if (!bus.in_ready) stalls++;
            end else begin
                bus.in_valid = 1'b0;
            end
        end
    endtask

    task automatic compare(string name, int n);
        check({name, " count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s[%0d]", name, i), got_q[i], exp_q[i]);
        end
    endtask

    task automatic single(int t, int z);
        @(posedge clk);
        #1;
        bus.T        = 9'(t);
        bus.in_valid = 1'b1;
        check($sformatf("in_ready T=%0d", t), int'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int c = 1; c < LAT; c++) begin
            check($sformatf("early out_valid T=%0d c=%0d", t, c), int'(bus.out_valid), 0);
            @(posedge clk);
            #1;
        end
        check($sformatf("out_valid T=%0d", t), int'(bus.out_valid), 1);
        check($sformatf("Z T=%0d", t), int'(bus.Z), z);
        @(posedge clk);
        #1;
        check($sformatf("out_valid drop T=%0d", t), int'(bus.out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{300, 49};
        vecs[1] = '{100, 100};
        vecs[2] = '{251, 0};
        vecs[3] = '{250, 250};
        vecs[4] = '{260, 9};
        vecs[5] = '{0, 0};
        vecs[6] = '{501, 250};
        vecs[7] = '{511, 4};

        bus.in_valid  = 1'b0;
        bus.T         = '0;
        bus.out_ready = 1'b0;
        ready_mode    = 0;
        clear();

        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", int'(bus.out_valid), 0);
        check("reset in_ready", int'(bus.in_ready), 0);
        check("reset Z", int'(bus.Z), 0);
        rst = 1'b1;
        #1;
        check("in_ready after reset", int'(bus.in_ready), 1);

        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            single(vecs[i].t, vecs[i].z);
        end

        clear();
        ready_mode = 0;
        for (int k = 1; k <= 6; k++) send_q.push_back(k);
        step(8);
        check("bp accepted", exp_q.size(), 4);
        check("bp in_ready low", int'(bus.in_ready), 0);
        check("bp out_valid held", int'(bus.out_valid), 1);
        check("bp Z held", int'(bus.Z), 1);
        ready_mode = 1;
        step(12);
        compare("bp", 6);
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            check($sformatf("bp order[%0d]", i), got_q[i], i + 1);
        end

        clear();
        ready_mode = 1;
        for (int k = 1; k <= 20; k++) send_q.push_back((k * 13) % 502);
        step(26);
        compare("stream", 20);
        check("stream stalls", stalls, 0);
        check("stream rate", last_pop - first_pop, 19);

        clear();
        ready_mode = 0;
        for (int k = 0; k < 12; k++) send_q.push_back(200 + k * 25);
        step(6);
        ready_mode = 2;
        step(30);
        ready_mode = 1;
        step(10);
        compare("toggle", 12);
        check("toggle max credits", max_inflight, 4);

        clear();
        ready_mode = 0;
        send_q.push_back(10);
        send_q.push_back(20);
        send_q.push_back(30);
        step(4);
        rst = 1'b0;
        #1;
        check("midreset out_valid", int'(bus.out_valid), 0);
        check("midreset in_ready", int'(bus.in_ready), 0);
        check("midreset Z", int'(bus.Z), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear();
        send_q.push_back(260);
        ready_mode = 1;
        step(8);
        compare("post-reset", 1);
        if (got_q.size() > 0) check("post-reset Z", got_q[0], 9);
        check("post-reset idle out_valid", int'(bus.out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/monty_final_sub.md
MONTY_FINAL_SUB -- requirements
Module: monty_final_sub

Interface
REQ-001 The block SHALL have parameter Q_LEN, default 60, giving the modulus width and the output width.
REQ-002 The block SHALL have parameter T_LEN, default Q_LEN+1, giving the width of the input partial result from the upstream word-reduction chain.
REQ-003 The block SHALL have parameter DEPTH, default 4, giving the output buffer entries; it SHALL be a power of two and at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port q, input, Q_LEN bits: the modulus, held static while any item is in flight.
REQ-007 The block SHALL have port in_valid, input, 1 bit: T is valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block can accept T.
REQ-009 The block SHALL have port T, input, T_LEN bits: the reduced value, in the range [0, 2q).
REQ-010 The block SHALL have port out_valid, output, 1 bit: Z is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts Z.
REQ-012 The block SHALL have port Z, output, Q_LEN bits: the fully reduced result.

Function
REQ-013 The block SHALL transfer an input when in_valid and in_ready are both high at a rising edge, and an output when out_valid and out_ready are both high.
REQ-014 Stage S1 SHALL compute D = T - q at T_LEN+1 bits and register D, a borrow flag, T and a valid bit.
REQ-015 Stage S2 SHALL select Z = T[Q_LEN-1:0] when borrow=1, or D[Q_LEN-1:0] when borrow=0, and write Z into the output buffer.
REQ-016 T equal to q SHALL give Z=0; T equal to q-1 SHALL give Z=q-1.
REQ-017 Latency SHALL be 2 cycles from input handshake to out_valid when the buffer is empty: out_valid is high in the second cycle after the handshake edge.
REQ-018 The output buffer SHALL be a DEPTH-entry circular FIFO with log2(DEPTH)-bit read and write pointers that wrap from DEPTH-1 to 0.
REQ-019 Z SHALL be driven directly from the entry at the read pointer.
REQ-020 A credit counter SHALL track stage-valids in flight plus buffer occupancy, ranging 0..DEPTH.
REQ-021 in_ready SHALL be high exactly when credits < DEPTH, so an in-flight item can never find the buffer full.
REQ-022 The credit counter SHALL change as follows:
- input handshake alone: +1
- output handshake alone: -1
- both in the same cycle: unchanged
- neither: unchanged
REQ-023 A simultaneous buffer write and read SHALL be legal at every occupancy, including empty-to-write with a same-cycle read of another entry.
REQ-024 When out_valid is high, Z and out_valid SHALL hold until the output handshake occurs.
REQ-025 Items SHALL leave in strict input order; none SHALL be dropped or duplicated.
REQ-026 Inputs of T >= 2q SHALL produce Z = (T-q) mod 2^Q_LEN and nothing more.

Reset
REQ-027 While rst=0, the block SHALL clear pointers, credits and all stage valid bits, and SHALL drive out_valid=0 and in_ready=0.
REQ-028 Z SHALL be 0 during reset; buffer data need not be cleared.
REQ-029 in_ready SHALL rise in the first cycle after rst deasserts.
REQ-030 A reset mid-operation SHALL discard every in-flight and buffered item; no stale out_valid SHALL appear after reset.

Configuration
REQ-031 Macro MONTY_FINAL_SUB_FF_IN_EN SHALL control an input register stage S0 that captures T and in_valid before S1.
REQ-032 With MONTY_FINAL_SUB_FF_IN_EN defined, latency SHALL be 3 cycles and the credit counter SHALL include S0 occupancy.
REQ-033 Without MONTY_FINAL_SUB_FF_IN_EN, S0 SHALL be absent and latency SHALL be 2 cycles.
REQ-034 All other behaviour SHALL be identical with and without MONTY_FINAL_SUB_FF_IN_EN.

Verification (Q_LEN=8, T_LEN=9, q=251, DEPTH=4, macro off unless stated)
REQ-035 Single inputs with out_ready=1, applied in turn: T=300 -> Z=49; T=100 -> Z=100; T=251 -> Z=0; T=250 -> Z=250; each with out_valid exactly 2 cycles after its handshake.
REQ-036 out_ready=0 with 6 back-to-back inputs T=1..6 -> in_ready falls after 4 accepts; out_ready=1 then yields Z=1,2,3,4 in order; T=5 and T=6 are accepted later and yield Z=5,6.
REQ-037 Continuous in_valid and out_ready=1 over 20 items T=k*13 mod 502 -> one result per cycle, in_ready stays high, every Z is correct, and pointers wrap 5 times.
REQ-038 Buffer full with out_ready toggling each cycle and in_valid=1 -> no loss or duplication; credits never exceed 4.
REQ-039 rst asserted with 3 items in flight -> out_valid=0 immediately; after release, a new T=260 yields Z=9 only.
REQ-040 Macro defined, T=300 -> Z=49 with out_valid 3 cycles after the handshake; the REQ-036 backpressure test SHALL still pass.
